// File: rtl/cplx_mac_pipe_if.sv
// Sample/coefficient input bundle and result output bundle
// for the pipelined complex multiply-accumulate unit.
interface cplx_mac_pipe_if #(
  parameter int DATA_W = 25,
  parameter int COEF_W = 27,
  parameter int OUT_W  = 32
);
  logic                     in_valid;
  logic                     in_first;
  logic                     in_last;
  logic                     in_mac;
  logic                     in_conj;
  logic signed [DATA_W-1:0] samp_i;
  logic signed [DATA_W-1:0] samp_q;
  logic signed [COEF_W-1:0] coef_i;
  logic signed [COEF_W-1:0] coef_q;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  out_i;
  logic signed [OUT_W-1:0]  out_q;
  logic                     out_sat;

  modport master (
    output in_valid, in_first, in_last, in_mac, in_conj,
    output samp_i, samp_q, coef_i, coef_q,
    input  out_valid, out_i, out_q, out_sat
  );

  modport slave (
    input  in_valid, in_first, in_last, in_mac, in_conj,
    input  samp_i, samp_q, coef_i, coef_q,
    output out_valid, out_i, out_q, out_sat
  );
endinterface

// File: rtl/cplx_mac_pipe.sv
// Complex multiply / accumulate with optional conjugation,
// round-half-up shift and saturation; 3-cycle latency.
module cplx_mac_pipe #(
  parameter int DATA_W = 25,
  parameter int COEF_W = 27,
  parameter int ACC_W  = 60,
  parameter int OUT_W  = 32,
  parameter int SHIFT  = 23
) (
  input logic            clk,
  input logic            reset,
  cplx_mac_pipe_if.slave bus
);
  localparam int PW = DATA_W + COEF_W;
  localparam int SW = PW + 1;
  localparam int RW = ACC_W + 1;

  localparam logic signed [RW-1:0] HALF =
    (SHIFT > 0) ? RW'(1) <<< (SHIFT > 0 ? SHIFT - 1 : 0) : '0;
  localparam logic signed [RW-1:0] OMAX =
    (RW'(1) <<< (OUT_W - 1)) - RW'(1);
  localparam logic signed [RW-1:0] OMIN =
    -(RW'(1) <<< (OUT_W - 1));

  typedef struct packed {
    logic              valid;
    logic              first;
    logic              last;
    logic              mac;
    logic              conj;
    logic [DATA_W-1:0] si;
    logic [DATA_W-1:0] sq;
    logic [COEF_W-1:0] ci;
    logic [COEF_W-1:0] cq;
  } s1_t;

  typedef struct packed {
    logic          valid;
    logic          first;
    logic          last;
    logic          mac;
    logic          conj;
    logic [PW-1:0] ii;
    logic [PW-1:0] iq;
    logic [PW-1:0] qi;
    logic [PW-1:0] qq;
  } s2_t;

  s1_t s1;
  s2_t s2;

  logic signed [ACC_W-1:0] acc_i, acc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
    end else begin
      s1.valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1.first <= bus.in_first;
        s1.last  <= bus.in_last;
        s1.mac   <= bus.in_mac;
        s1.conj  <= bus.in_conj;
        s1.si    <= bus.samp_i;
        s1.sq    <= bus.samp_q;
        s1.ci    <= bus.coef_i;
        s1.cq    <= bus.coef_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2 <= '0;
    end else begin
      s2.valid <= s1.valid;
      if (s1.valid) begin
        s2.first <= s1.first;
        s2.last  <= s1.last;
        s2.mac   <= s1.mac;
        s2.conj  <= s1.conj;
        s2.ii <= PW'($signed(s1.si)) * PW'($signed(s1.ci));
        s2.iq <= PW'($signed(s1.si)) * PW'($signed(s1.cq));
        s2.qi <= PW'($signed(s1.sq)) * PW'($signed(s1.ci));
        s2.qq <= PW'($signed(s1.sq)) * PW'($signed(s1.cq));
      end
    end
  end

  logic signed [SW-1:0]    ii, iq, qi, qq;
  logic signed [SW-1:0]    p_i_s, p_q_s;
  logic signed [ACC_W-1:0] p_i, p_q;
  logic signed [ACC_W-1:0] base_i, base_q;
  logic signed [ACC_W-1:0] sum_i, sum_q;
  logic signed [ACC_W-1:0] res_i, res_q;
  logic [OUT_W:0]          rs_i, rs_q;
  logic                    emit;

  assign ii = SW'($signed(s2.ii));
  assign iq = SW'($signed(s2.iq));
  assign qi = SW'($signed(s2.qi));
  assign qq = SW'($signed(s2.qq));

  assign p_i_s = s2.conj ? ii + qq : ii - qq;
  assign p_q_s = s2.conj ? qi - iq : iq + qi;
  assign p_i   = ACC_W'(p_i_s);
  assign p_q   = ACC_W'(p_q_s);

  // A first flag restarts the sum, dropping any unfinished burst
  assign base_i = s2.first ? '0 : acc_i;
  assign base_q = s2.first ? '0 : acc_q;
  assign sum_i  = base_i + p_i;
  assign sum_q  = base_q + p_q;
  assign res_i  = s2.mac ? sum_i : p_i;
  assign res_q  = s2.mac ? sum_q : p_q;
  assign emit   = s2.valid && (!s2.mac || s2.last);

  function automatic logic [OUT_W:0] rsat(
    input logic signed [ACC_W-1:0] x
  );
    logic signed [RW-1:0] r;
    r = (RW'(x) + HALF) >>> SHIFT;
    if (r > OMAX)
      rsat = {1'b1, OMAX[OUT_W-1:0]};
    else if (r < OMIN)
      rsat = {1'b1, OMIN[OUT_W-1:0]};
    else
      rsat = {1'b0, r[OUT_W-1:0]};
  endfunction

  assign rs_i = rsat(res_i);
  assign rs_q = rsat(res_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_i         <= '0;
      acc_q         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_i     <= '0;
      bus.out_q     <= '0;
      bus.out_sat   <= 1'b0;
    end else begin
      if (s2.valid && s2.mac) begin
        acc_i <= s2.last ? '0 : sum_i;
        acc_q <= s2.last ? '0 : sum_q;
      end
      bus.out_valid <= emit;
      if (emit) begin
        bus.out_i   <= rs_i[OUT_W-1:0];
        bus.out_q   <= rs_q[OUT_W-1:0];
        bus.out_sat <= rs_i[OUT_W] | rs_q[OUT_W];
      end
    end
  end
endmodule

// File: tb/tb_cplx_mac_pipe.sv
// Directed bench for cplx_mac_pipe: three instances cover
// SHIFT=0/OUT_W=32, SHIFT=1/OUT_W=32 and SHIFT=0/OUT_W=16.
module tb_cplx_mac_pipe;
  localparam int DW = 25;
  localparam int CW = 27;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                 in_valid, in_first, in_last;
  logic                 in_mac, in_conj;
  logic signed [DW-1:0] samp_i, samp_q;
  logic signed [CW-1:0] coef_i, coef_q;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_d
      cplx_mac_pipe_if #(
        .DATA_W(DW), .COEF_W(CW),
        .OUT_W(g == 2 ? 16 : 32)
      ) b ();
      assign b.in_valid = in_valid;
      assign b.in_first = in_first;
      assign b.in_last  = in_last;
      assign b.in_mac   = in_mac;
      assign b.in_conj  = in_conj;
      assign b.samp_i   = samp_i;
      assign b.samp_q   = samp_q;
      assign b.coef_i   = coef_i;
      assign b.coef_q   = coef_q;
      cplx_mac_pipe #(
        .DATA_W(DW), .COEF_W(CW), .ACC_W(60),
        .OUT_W(g == 2 ? 16 : 32),
        .SHIFT(g == 1 ? 1 : 0)
      ) dut (
        .clk(clk), .reset(reset), .bus(b)
      );
    end
  endgenerate

  typedef struct {
    logic v, f, l, m, c;
    int   si, sq, ci, cq;
  } stim_t;

  typedef struct {
    stim_t s;
    int    sel;
    int    ei, eq;
    logic  es;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic stim_t mk(
    input logic v, f, l, m, c,
    input int si, sq, ci, cq
  );
    stim_t s;
    s.v = v; s.f = f; s.l = l; s.m = m; s.c = c;
    s.si = si; s.sq = sq; s.ci = ci; s.cq = cq;
    return s;
  endfunction

  function automatic void rd(
    input int sel, output logic v,
    output int i, output int q, output logic s
  );
    case (sel)
      1: begin
        v = g_d[1].b.out_valid; i = g_d[1].b.out_i;
        q = g_d[1].b.out_q;     s = g_d[1].b.out_sat;
      end
      2: begin
        v = g_d[2].b.out_valid; i = g_d[2].b.out_i;
        q = g_d[2].b.out_q;     s = g_d[2].b.out_sat;
      end
      default: begin
        v = g_d[0].b.out_valid; i = g_d[0].b.out_i;
        q = g_d[0].b.out_q;     s = g_d[0].b.out_sat;
      end
    endcase
  endfunction

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    in_valid = s.v; in_first = s.f; in_last = s.l;
    in_mac   = s.m; in_conj  = s.c;
    samp_i = DW'(s.si); samp_q = DW'(s.sq);
    coef_i = CW'(s.ci); coef_q = CW'(s.cq);
  endtask

  // check outputs at this falling edge, then apply next input
  task automatic step(
    input stim_t s, input int sel, input string nm,
    input logic ev, input int ei, input int eq, input logic es
  );
    logic v, os;
    int   oi, oq;
    @(negedge clk);
    rd(sel, v, oi, oq, os);
    cmp({nm, " valid"}, int'(v), int'(ev));
    if (ev) begin
      cmp({nm, " out_i"}, oi, ei);
      cmp({nm, " out_q"}, oq, eq);
      cmp({nm, " sat"}, int'(os), int'(es));
    end
    drive(s);
  endtask

  stim_t idle, fm, mm, lm, fl, pr;
  vec_t  tv[14];

  initial begin
    logic v, os;
    int   oi, oq;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    tv[0]  = '{mk(1,0,0,0,0, 3, 4, 2,-1), 0, 10, 5, 1'b0};
    tv[1]  = '{mk(1,0,0,0,1, 3, 4, 2,-1), 0, 2, 11, 1'b0};
    tv[2]  = '{mk(1,0,0,0,0, 5, 0, 1, 0), 1, 3, 0, 1'b0};
    tv[3]  = '{mk(1,0,0,0,0,-5, 0, 1, 0), 1, -2, 0, 1'b0};
    tv[4]  = '{mk(1,0,0,0,0, 4, 0, 1, 0), 1, 2, 0, 1'b0};
    tv[5]  = '{mk(1,0,0,0,0,-7, 3, 5, 2), 1, -20, 1, 1'b0};
    tv[6]  = '{mk(1,0,0,0,1,-7, 3, 5, 2), 0, -29, 29, 1'b0};
    tv[7]  = '{mk(1,0,0,0,0, 1<<20, 0, 1<<10, 0),
               2, 32767, 0, 1'b1};
    tv[8]  = '{mk(1,0,0,0,0, -(1<<20), 0, 1<<10, 0),
               2, -32768, 0, 1'b1};
    tv[9]  = '{mk(1,0,0,0,0, 1<<20, 0, 1<<10, 0),
               0, 1<<30, 0, 1'b0};
    tv[10] = '{mk(1,0,0,0,0, 32767, 0, 1, 0),
               2, 32767, 0, 1'b0};
    tv[11] = '{mk(1,0,0,0,0, -32768, 0, 1, 0),
               2, -32768, 0, 1'b0};
    tv[12] = '{mk(1,0,0,0,0, 0, 1<<20, 1<<10, 0),
               2, 0, 32767, 1'b1};
    tv[13] = '{mk(1,0,0,0,0, 32768, 0, 1, 0),
               2, 32767, 0, 1'b1};

    reset = 1'b1;
    drive(idle);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rd(k, v, oi, oq, os);
      cmp($sformatf("rst%0d valid", k), int'(v), 0);
      cmp($sformatf("rst%0d out_i", k), oi, 0);
      cmp($sformatf("rst%0d out_q", k), oq, 0);
      cmp($sformatf("rst%0d sat", k), int'(os), 0);
    end
    reset = 1'b0;

    for (int n = 0; n < 14; n++) begin
      string nm;
      nm = $sformatf("vec%0d", n);
      step(tv[n].s, tv[n].sel, nm, 0, 0, 0, 0);
      step(idle, tv[n].sel, nm, 0, 0, 0, 0);
      step(idle, tv[n].sel, nm, 0, 0, 0, 0);
      step(idle, tv[n].sel, nm, 1,
           tv[n].ei, tv[n].eq, tv[n].es);
    end

    // two back-to-back bursts, no bubble between them
    fm = mk(1, 1, 0, 1, 0, 1, 1, 1, 0);
    mm = mk(1, 0, 0, 1, 0, 1, 1, 1, 0);
    lm = mk(1, 0, 1, 1, 0, 1, 1, 1, 0);
    fl = mk(1, 1, 1, 1, 0, 2, 0, 0, 1);
    step(fm,   0, "mac k0", 0, 0, 0, 0);
    step(mm,   0, "mac k1", 0, 0, 0, 0);
    step(lm,   0, "mac k2", 0, 0, 0, 0);
    step(fl,   0, "mac k3", 0, 0, 0, 0);
    step(idle, 0, "mac k4", 0, 0, 0, 0);
    step(idle, 0, "mac k5", 1, 3, 3, 0);
    step(idle, 0, "mac k6", 1, 0, 2, 0);
    step(idle, 0, "mac k7", 0, 0, 0, 0);

    // reset after a partial sum has reached the accumulator
    step(fm,   0, "rsq k0", 0, 0, 0, 0);
    step(mm,   0, "rsq k1", 0, 0, 0, 0);
    step(idle, 0, "rsq k2", 0, 0, 0, 0);
    step(idle, 0, "rsq k3", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rd(0, v, oi, oq, os);
    cmp("rsq in-reset valid", int'(v), 0);
    cmp("rsq in-reset out_q", oq, 0);
    reset = 1'b0;
    lm = mk(1, 0, 1, 1, 0, 1, 0, 1, 0);
    fl = mk(1, 1, 1, 1, 0, 1, 0, 1, 0);
    step(lm,   0, "rsq k6", 0, 0, 0, 0);
    step(idle, 0, "rsq k7", 0, 0, 0, 0);
    step(idle, 0, "rsq k8", 0, 0, 0, 0);
    step(fl,   0, "rsq k9", 1, 1, 0, 0);
    step(idle, 0, "rsq k10", 0, 0, 0, 0);
    step(idle, 0, "rsq k11", 0, 0, 0, 0);
    step(idle, 0, "rsq k12", 1, 1, 0, 0);
    step(idle, 0, "rsq k13", 0, 0, 0, 0);

    // product-mode sample inside a MAC burst
    lm = mk(1, 0, 1, 1, 0, 1, 1, 1, 0);
    pr = mk(1, 0, 0, 0, 0, 3, 4, 2, -1);
    step(fm,   0, "ilv k0", 0, 0, 0, 0);
    step(pr,   0, "ilv k1", 0, 0, 0, 0);
    step(lm,   0, "ilv k2", 0, 0, 0, 0);
    step(idle, 0, "ilv k3", 0, 0, 0, 0);
    step(idle, 0, "ilv k4", 1, 10, 5, 0);
    step(idle, 0, "ilv k5", 1, 2, 2, 0);
    step(idle, 0, "ilv k6", 0, 0, 0, 0);
    rd(0, v, oi, oq, os);
    cmp("hold out_i", oi, 2);
    cmp("hold out_q", oq, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cplx_mac_pipe.md
Name: cplx_mac_pipe

Overview:
- Parametrised, fully pipelined complex multiply-accumulate unit for the FIR datapath.
- Multiplies a complex sample by a complex coefficient, with optional coefficient conjugation.
- Optionally accumulates products over a burst delimited by first/last flags.
- Rounds, shifts and saturates the result to an output width. Emits one valid-qualified result per product (product mode) or per burst (MAC mode).

Parameters:
- DATA_W, 25: signed sample width (I and Q each).
- COEF_W, 27: signed coefficient width (I and Q each).
- ACC_W, 60: signed accumulator width; must be >= DATA_W+COEF_W+1.
- OUT_W, 32: signed output width; must be <= ACC_W.
- SHIFT, 23: arithmetic right shift applied before output rounding (0 allowed).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample/coef pair valid this cycle.
- in_first  in  1  first product of a burst (qualified by in_valid).
- in_last  in  1  last product of a burst (qualified by in_valid).
- in_mac  in  1  1 = accumulate mode, 0 = product mode (sampled with each sample).
- in_conj  in  1  1 = use conjugate of coefficient.
- samp_i, samp_q  in  DATA_W each  signed sample.
- coef_i, coef_q  in  COEF_W each  signed coefficient.
- out_valid  out  1  result valid, single-cycle pulse per result.
- out_i, out_q  out  OUT_W each  signed result.
- out_sat  out  1  1 if I or Q saturated for this result.

Behaviour:
- Reset (async assert, sync-safe deassert): all pipeline valids, accumulator, out_valid, out_i, out_q and out_sat forced to 0. A partially accumulated burst is discarded.
- All arithmetic is signed two's complement. No backpressure; one sample is accepted every cycle in_valid=1.
- Stage 1 (register): capture inputs and control flags when in_valid. Control flags are don't-care when in_valid=0.
- Stage 2 (multiply): four products II, IQ, QI, QQ, each DATA_W+COEF_W bits.
- Stage 3 (combine/accumulate), sum width DATA_W+COEF_W+1, sign-extended to ACC_W:
  - Normal: P_I = II - QQ, P_Q = IQ + QI.
  - Conjugate: P_I = II + QQ, P_Q = QI - IQ.
- Product mode (mac=0): result = P. out_valid asserts exactly 3 cycles after the in_valid cycle. The accumulator is untouched.
- MAC mode (mac=1):
  - first=1: acc <= P, discarding any prior partial sum.
  - first=0: acc <= acc + P.
  - last=1: the post-update acc value is emitted (out_valid 3 cycles after the last sample) and acc clears to 0 in the same cycle.
  - first=1 and last=1 on the same sample: emits P alone.
  - A MAC sample with no preceding first accumulates onto the current acc (0 after reset or after a last).
  - The accumulator wraps modulo ACC_W; no overflow detection in acc.
- Mixed modes: a product-mode sample interleaved inside a MAC burst is emitted independently and does not disturb acc.
- Output stage (registered, part of the 3-cycle latency), per component:
  - r = (x + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, i.e. round half up.
  - If r > 2^(OUT_W-1)-1, out = max and sat=1; if r < -2^(OUT_W-1), out = min and sat=1.
  - out_sat = sat_I | sat_Q.
- Hold behaviour: out_i, out_q and out_sat hold their last value when out_valid=0.
- Throughput: 1 sample/cycle. Back-to-back bursts (last followed immediately by first) are supported with no bubble.

Test Plan:
1. Product mode, SHIFT=0: samp=(3,4), coef=(2,-1), conj=0 -> 3 cycles later out_valid=1, out=(10,5), sat=0. Same input with conj=1 -> out=(2,11).
2. MAC mode, SHIFT=0: 3 consecutive samples (1,1)x(1,0), flags first/–/last -> exactly one out_valid, out=(3,3). An immediately following burst of (2,0)x(0,1), first&last -> out=(0,2) on the next cycle.
3. Rounding, SHIFT=1: product I=5 -> 3; I=-5 -> -2; I=4 -> 2.
4. Saturation, OUT_W=16, SHIFT=0: samp=(2^20,0), coef=(2^10,0) -> out_i=32767, out_sat=1. samp=(-2^20,0), same coef -> out_i=-32768, out_sat=1.
5. Reset mid-burst: first plus one more MAC sample, assert reset for 1 cycle, then issue first&last (1,0)x(1,0) -> no spurious out_valid; result out=(1,0) with no prior partial sum included.
6. Interleave: a product-mode sample between first and last of a MAC burst -> product emitted at its own +3 cycle; burst sum excludes it.
